fnd_scan_controller: RTL and testbench



---
 rtl/fnd_pkg.sv | 22 ++
 rtl/fnd_seg_decoder.sv | 23 ++
 rtl/fnd_scan_controller.sv | 159 +++++++++++++++
 tb/tb_fnd_scan_controller.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants, FSM encoding and helpers for the multiplexed FND controller.
package fnd_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Active-low a..g patterns for 0..F, dp bit left high (off).
  localparam logic [0:15][7:0] HEX_SEG = {
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/fnd_seg_decoder.sv
// One digit of segment drive: nibble plus blank/dash/dp to active-low pins.
// Purely combinational; dash overrides blank, dp is applied in every case.
module fnd_seg_decoder
  import fnd_pkg::*;
(
  input  logic       [3:0] nibble,
  input  logic             blank,
  input  logic             dash,
  input  logic             dp,
  output logic       [7:0] seg
);

  always_comb begin
    if (dash)
      seg = SEG_DASH;
    else if (blank)
      seg = SEG_BLANK;
    else
      seg = HEX_SEG[nibble];
    seg[7] = ~dp;
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// Binary-to-BCD (double dabble, DATA_W+1 cycles) or hex capture into a display register,
// scanned over NUM_DIGITS common-anode digits; loads while busy are dropped, scanning never stalls.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int DATA_W     = 14,
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     value,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic                  busy,
  output logic [NUM_DIGITS-1:0] seg_comm,
  output logic [7:0]            seg
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  state_t                  state;
  logic [DATA_W-1:0]       val_q;
  logic [DATA_W-1:0]       bin_q;
  logic                    hex_q;
  logic                    blz_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [BCD_W-1:0]        bcd_q;

  logic [BCD_W-1:0]        disp_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic [NUM_DIGITS-1:0]   disp_dp_q;
  logic                    ovf_q;

  logic [DIV_W-1:0]        div_q;
  logic [IDX_W-1:0]        idx_q;

  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W-1:0]        nib_next;
  logic [NUM_DIGITS-1:0]   blank_next;
  logic                    ovf_next;
  logic                    zrun;
  logic [DATA_W+BCD_W-1:0] val_ext;
  logic [3:0]              cur_nib;
  logic [7:0]              seg_next;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  assign val_ext = {{BCD_W{1'b0}}, val_q};

  // Commit-time view: digits, overflow and leading-zero run from the top digit down.
  always_comb begin
    nib_next   = hex_q ? val_ext[BCD_W-1:0] : bcd_q;
    ovf_next   = hex_q ? |(val_ext >> BCD_W) : (64'(val_q) >= pow10(NUM_DIGITS));
    zrun       = blz_q;
    blank_next = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zrun          = zrun && (nib_next[4*i +: 4] == 4'd0);
      blank_next[i] = zrun;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      val_q     <= '0;
      bin_q     <= '0;
      hex_q     <= 1'b0;
      blz_q     <= 1'b0;
      dp_q      <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      disp_q    <= '0;
      blank_q   <= '0;
      disp_dp_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            val_q <= value;
            bin_q <= value;
            hex_q <= hex_mode;
            blz_q <= blank_lz;
            dp_q  <= dp_mask;
            cnt_q <= CNT_INIT;
            bcd_q <= '0;
            busy  <= 1'b1;
            state <= hex_mode ? COMMIT : SHIFT;
          end
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          cnt_q          <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state <= COMMIT;
        end
        COMMIT: begin
          disp_q    <= nib_next;
          blank_q   <= blank_next;
          disp_dp_q <= dp_q;
          ovf_q     <= ovf_next;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
      idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign cur_nib = disp_q[4*idx_q +: 4];

  fnd_seg_decoder u_dec (
    .nibble (cur_nib),
    .blank  (blank_q[idx_q]),
    .dash   (ovf_q),
    .dp     (disp_dp_q[idx_q]),
    .seg    (seg_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_comm <= '1;
      seg      <= SEG_BLANK;
    end else begin
      seg_comm <= ~(NUM_DIGITS'(1) << idx_q);
      seg      <= seg_next;
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed and random loads against an arithmetic digit model of the FND controller.
module tb_fnd_scan_controller;

  localparam int DATA_W     = 14;
  localparam int NUM_DIGITS = 4;
  localparam int SCAN_DIV   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] value = '0;
  logic        load = 1'b0;
  logic        hex_mode = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  dp_mask = '0;
  logic        busy;
  logic [3:0]  seg_comm;
  logic [7:0]  seg;

  int ncmp = 0;
  int nerr = 0;
  logic [7:0] exp_seg [NUM_DIGITS];
  logic [7:0] seg_tab [16];

  always #5 clk = ~clk;

  fnd_scan_controller #(
    .DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .hex_mode(hex_mode),
    .blank_lz(blank_lz), .dp_mask(dp_mask), .busy(busy), .seg_comm(seg_comm), .seg(seg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected pattern per digit straight from the display rules, using division by the radix.
  function automatic void set_model(input int unsigned v, input bit hx, input bit blz,
                                    input logic [3:0] dp);
    int unsigned base, scale, d;
    bit ovf, blank;
    base  = hx ? 16 : 10;
    ovf   = v >= base ** NUM_DIGITS;
    scale = 1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d     = (v / scale) % base;
      blank = blz && (i > 0) && ((v / scale) == 0);
      if (ovf)        exp_seg[i] = 8'hBF;
      else if (blank) exp_seg[i] = 8'hFF;
      else            exp_seg[i] = seg_tab[d];
      exp_seg[i][7] = ~dp[i];
      scale = scale * base;
    end
  endfunction

  function automatic int digit_of(input logic [3:0] sc);
    digit_of = -1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (sc == ~(4'b0001 << i)) digit_of = i;
  endfunction

  task automatic check_scan(input int ncyc, input bit first_full);
    int idx, pidx, run;
    bit known;
    pidx  = first_full ? 0 : -1;
    run   = first_full ? 1 : 0;
    known = first_full;
    repeat (ncyc) begin
      @(posedge clk); #1;
      idx = digit_of(seg_comm);
      chk("busy_idle", busy, 0);
      chk("comm_onehot", (idx >= 0), 1);
      if (idx >= 0) chk($sformatf("seg_d%0d", idx), seg, exp_seg[idx]);
      if (idx == pidx) begin
        run++;
      end else begin
        if (pidx >= 0 && idx >= 0) begin
          chk("scan_order", idx, (pidx + 1) % NUM_DIGITS);
          if (known) chk("dwell", run, SCAN_DIV);
          known = 1;
        end
        pidx = idx;
        run  = 1;
      end
    end
  endtask

  // intr_at: sample number (1 = right after the accepted load) at which a competing load is driven.
  task automatic do_load(input int unsigned v, input bit hx, input bit blz,
                         input logic [3:0] dp, input int intr_at);
    int cnt, idx;
    bit done;
    @(posedge clk); #1;
    value = v[13:0]; hex_mode = hx; blank_lz = blz; dp_mask = dp; load = 1'b1;
    cnt = 0;
    done = 0;
    for (int s = 1; s <= 40 && !done; s++) begin
      @(posedge clk); #1;
      load = 1'b0;
      if (busy === 1'b1) begin
        cnt++;
        if (s == intr_at) begin
          value = ~v[13:0]; hex_mode = ~hx; blank_lz = ~blz; dp_mask = ~dp; load = 1'b1;
        end
      end else begin
        done = 1;
        idx = digit_of(seg_comm);
        if (idx >= 0) chk("seg_before_update", seg, exp_seg[idx]);
      end
    end
    chk(hx ? "busy_len_hex" : "busy_len_dec", cnt, hx ? 1 : DATA_W + 1);
    set_model(v, hx, blz, dp);
    check_scan(2 * NUM_DIGITS * SCAN_DIV, 0);
  endtask

  initial begin
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_comm", seg_comm, 4'b1111);
    chk("rst_seg", seg, 8'hFF);
    rst_n = 1'b1;
    set_model(0, 0, 0, 4'b0000);
    @(posedge clk); #1;
    chk("first_comm", seg_comm, 4'b1110);
    chk("first_seg", seg, 8'hC0);
    check_scan(40, 1);

    do_load(1234, 0, 0, 4'b0000, -1);
    do_load(7, 0, 1, 4'b0010, -1);
    do_load(12345, 0, 0, 4'b0000, -1);
    do_load(12345, 1, 0, 4'b0000, -1);
    do_load(42, 0, 1, 4'b0000, 3);
    do_load(321, 0, 0, 4'b0101, DATA_W + 1);
    do_load(16'h00A0, 1, 1, 4'b1000, -1);

    for (int n = 0; n < 12; n++) begin
      int unsigned rv;
      rv = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 120) : $urandom_range(0, 16383);
      do_load(rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), -1);
    end

    // Abort a conversion of 9999 with reset; nothing of it may reach the display.
    @(posedge clk); #1;
    value = 14'd9999; hex_mode = 1'b0; blank_lz = 1'b0; dp_mask = 4'b0000; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    chk("abort_busy_on", busy, 1);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_comm", seg_comm, 4'b1111);
    chk("abort_seg", seg, 8'hFF);
    rst_n = 1'b1;
    set_model(0, 0, 0, 4'b0000);
    @(posedge clk); #1;
    chk("abort_first_comm", seg_comm, 4'b1110);
    chk("abort_first_seg", seg, 8'hC0);
    check_scan(40, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
